spi_reg_bank: RTL and testbench

Parametrised SPI (mode 0) peripheral with a read/write register bank. It sits between the external SPI pins and the on-chip control logic (output-enable, PWM-enable and duty-cycle consumers) and exposes every register as a flat bus. Unlike the earlier write-only peripheral, it supports readback over CIPO, a configurable register count and width, commit strobes, and framing-error reporting.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_reg_bank_if.sv | 26 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_reg_bank.sv | 171 +++++++++++++++++
 tb/tb_spi_reg_bank.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register bank: FSM states, R/W flag
// encoding and frame-length arithmetic.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int unsigned frame_width(input int unsigned addr_w,
                                                input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an external controller and the register bank.
interface spi_reg_bank_if;

    logic sclk;
    logic ncs;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (
        output sclk,
        output ncs,
        output copi,
        input  cipo,
        input  cipo_oe
    );

    modport slave (
        input  sclk,
        input  ncs,
        input  copi,
        output cipo,
        output cipo_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus history flop; edges come from stage 2 vs history.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_s1;
    logic r_s2;
    logic r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_hist <= r_s2;
        end
    end

    assign o_sync   = r_s2;
    assign o_rise_c = r_s2 & ~r_hist;
    assign o_fall_c = ~r_s2 & r_hist;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral with a readable/writable register bank, commit strobe
// and framing-error pulse.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int unsigned FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int unsigned MAX_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W   = $clog2(MAX_W + 1);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ncs_sync,  w_ncs_rise,  w_ncs_fall;
    logic w_copi_sync, w_copi_rise, w_copi_fall;
    logic w_unused;

    spi_sync_edge u_sync_sclk (.clk(clk), .rst(rst), .i_async(spi.sclk),
        .o_sync(w_sclk_sync), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall));
    spi_sync_edge u_sync_ncs  (.clk(clk), .rst(rst), .i_async(spi.ncs),
        .o_sync(w_ncs_sync),  .o_rise_c(w_ncs_rise),  .o_fall_c(w_ncs_fall));
    spi_sync_edge u_sync_copi (.clk(clk), .rst(rst), .i_async(spi.copi),
        .o_sync(w_copi_sync), .o_rise_c(w_copi_rise), .o_fall_c(w_copi_fall));

    assign w_unused = ^{w_sclk_sync, w_copi_rise, w_copi_fall};

    state_e                     r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [FRAME_W-1:0]         r_shift_in, w_shift_in_nxt, w_shift_in_sh;
    logic [DATA_W-1:0]          r_shift_out, w_shift_out_nxt;
    logic [NUM_REGS*DATA_W-1:0] r_regs;
    logic                       r_cipo, r_cipo_oe, r_wr_strobe, r_frame_err;
    logic [ADDR_W-1:0]          r_wr_addr;
    logic                       w_commit, w_err, w_cipo_nxt;
    logic                       w_frame_wr, w_addr_ok;
    logic [ADDR_W-1:0]          w_frame_addr, w_rd_addr;
    logic [DATA_W-1:0]          w_frame_data, w_rd_data;

    // Completed-frame fields, valid once the FSM reaches DONE
    assign w_frame_wr    = r_shift_in[FRAME_W-1];
    assign w_frame_addr  = r_shift_in[DATA_W +: ADDR_W];
    assign w_frame_data  = r_shift_in[DATA_W-1:0];
    assign w_addr_ok     = 32'(w_frame_addr) < NUM_REGS;
    assign w_shift_in_sh = {r_shift_in[FRAME_W-2:0], w_copi_sync};
    assign w_rd_addr     = w_shift_in_sh[ADDR_W-1:0];

    // Read lookup; unmatched (out-of-range) addresses return zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_addr == ADDR_W'(i)) begin
                w_rd_data = r_regs[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_in_nxt  = r_shift_in;
        w_shift_out_nxt = r_shift_out;
        w_commit        = 1'b0;
        w_err           = 1'b0;
        if (w_ncs_fall) begin
            w_state_nxt     = CMD;
            w_cnt_nxt       = '0;
            w_shift_in_nxt  = '0;
            w_shift_out_nxt = '0;
        end else if (w_ncs_rise) begin
            if (r_state != IDLE) begin
                w_state_nxt = IDLE;
                w_err       = (r_state != DONE) || !w_addr_ok;
                w_commit    = (r_state == DONE) && (w_frame_wr == RW_WRITE) && w_addr_ok;
            end
        end else begin
            if (w_sclk_rise && (r_state == CMD || r_state == ADDR || r_state == DATA)) begin
                w_shift_in_nxt = w_shift_in_sh;
            end
            case (r_state)
                CMD: begin
                    if (w_sclk_rise) begin
                        w_state_nxt = ADDR;
                        w_cnt_nxt   = '0;
                    end
                end
                ADDR: begin
                    if (w_sclk_rise) begin
                        if (r_cnt == CNT_W'(ADDR_W - 1)) begin
                            w_state_nxt     = DATA;
                            w_cnt_nxt       = '0;
                            w_shift_out_nxt = w_rd_data;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    // The fall trailing the last address bit must not shift out the MSB
                    if (w_sclk_rise) begin
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            w_state_nxt = DONE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else if (w_sclk_fall && r_cnt != '0) begin
                        w_shift_out_nxt = {r_shift_out[DATA_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
        w_cipo_nxt = (w_state_nxt == DATA) ? w_shift_out_nxt[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_regs      <= '0;
            r_cipo      <= 1'b0;
            r_cipo_oe   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_shift_in  <= w_shift_in_nxt;
            r_shift_out <= w_shift_out_nxt;
            r_cipo      <= w_cipo_nxt;
            r_cipo_oe   <= ~w_ncs_sync;
            r_wr_strobe <= w_commit;
            r_frame_err <= w_err;
            if (w_commit) begin
                r_wr_addr <= w_frame_addr;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && w_frame_addr == ADDR_W'(i)) begin
                    r_regs[i*DATA_W +: DATA_W] <= w_frame_data;
                end
            end
        end
    end

    assign spi.cipo    = r_cipo;
    assign spi.cipo_oe = r_cipo_oe;
    assign regs_flat   = r_regs;
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, readback, range/short-frame errors,
// mid-frame reset and back-to-back frames.
module tb_spi_reg_bank;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] regs_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_err;

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   strobe_cnt = 0;
    int   err_cnt    = 0;
    logic oe_mid     = 1'b0;

    always #5 clk = ~clk;

    spi_reg_bank_if spi_bus ();

    spi_reg_bank #(
        .NUM_REGS (5),
        .ADDR_W   (7),
        .DATA_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi_bus),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    always @(posedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (frame_err) err_cnt    <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Controller side of one frame; rd collects cipo just before each data-bit rise
    task automatic spi_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                             input int nbits, input bit raise, output logic [7:0] rd);
        logic [15:0] f;
        f  = {rw, addr, data};
        rd = '0;
        spi_bus.ncs = 1'b0;
        clks(HALF);
        oe_mid = spi_bus.cipo_oe;
        for (int i = 0; i < nbits; i++) begin
            spi_bus.copi = f[15-i];
            clks(HALF);
            if (i >= 8) rd = {rd[6:0], spi_bus.cipo};
            spi_bus.sclk = 1'b1;
            clks(HALF);
            spi_bus.sclk = 1'b0;
        end
        clks(HALF);
        if (raise) begin
            spi_bus.ncs = 1'b1;
            clks(2*HALF);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int s0, e0;
        spi_bus.sclk = 1'b0;
        spi_bus.ncs  = 1'b1;
        spi_bus.copi = 1'b0;
        clks(3);
        check("rst_regs",    64'(regs_flat),       64'h0);
        check("rst_cipo",    64'(spi_bus.cipo),    64'h0);
        check("rst_cipo_oe", 64'(spi_bus.cipo_oe), 64'h0);
        check("rst_strobe",  64'(wr_strobe),       64'h0);
        check("rst_wr_addr", 64'(wr_addr),         64'h0);
        check("rst_ferr",    64'(frame_err),       64'h0);
        rst = 1'b0;
        clks(HALF);

        // Write 0xAA to reg 2
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(1'b1, 7'd2, 8'hAA, 16, 1'b1, rd);
        check("w2_oe_mid",  64'(oe_mid),          64'h1);
        check("w2_reg",     64'(regs_flat[23:16]), 64'hAA);
        check("w2_flat",    64'(regs_flat),       64'h00_00_AA_00_00);
        check("w2_strobes", 64'(strobe_cnt - s0), 64'd1);
        check("w2_wr_addr", 64'(wr_addr),         64'd2);
        check("w2_ferr",    64'(err_cnt - e0),    64'd0);
        check("idle_oe",    64'(spi_bus.cipo_oe), 64'h0);

        // Write 0x3C to reg 4 then read it back
        spi_frame(1'b1, 7'd4, 8'h3C, 16, 1'b1, rd);
        check("w4_flat", 64'(regs_flat), 64'h3C_00_AA_00_00);
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(1'b0, 7'd4, 8'h5A, 16, 1'b1, rd);
        check("r4_data",    64'(rd),              64'h3C);
        check("r4_flat",    64'(regs_flat),       64'h3C_00_AA_00_00);
        check("r4_strobes", 64'(strobe_cnt - s0), 64'd0);
        check("r4_ferr",    64'(err_cnt - e0),    64'd0);
        check("r4_wr_addr", 64'(wr_addr),         64'd4);
        check("idle_cipo",  64'(spi_bus.cipo),    64'h0);

        // Out-of-range write and read
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(1'b1, 7'h05, 8'hFF, 16, 1'b1, rd);
        check("w5_flat",    64'(regs_flat),       64'h3C_00_AA_00_00);
        check("w5_ferr",    64'(err_cnt - e0),    64'd1);
        check("w5_strobes", 64'(strobe_cnt - s0), 64'd0);
        e0 = err_cnt;
        spi_frame(1'b0, 7'h09, 8'h00, 16, 1'b1, rd);
        check("r9_data", 64'(rd),           64'h0);
        check("r9_ferr", 64'(err_cnt - e0), 64'd1);

        // Short frame: 10 bits of a write to reg 1
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(1'b1, 7'd1, 8'h77, 10, 1'b1, rd);
        check("short_flat",    64'(regs_flat),       64'h3C_00_AA_00_00);
        check("short_ferr",    64'(err_cnt - e0),    64'd1);
        check("short_strobes", 64'(strobe_cnt - s0), 64'd0);

        // Reset during the data phase of a write to reg 0
        spi_frame(1'b1, 7'd0, 8'h99, 12, 1'b0, rd);
        rst = 1'b1;
        clks(2);
        check("mrst_flat",    64'(regs_flat),       64'h0);
        check("mrst_cipo",    64'(spi_bus.cipo),    64'h0);
        check("mrst_cipo_oe", 64'(spi_bus.cipo_oe), 64'h0);
        check("mrst_strobe",  64'(wr_strobe),       64'h0);
        check("mrst_wr_addr", 64'(wr_addr),         64'h0);
        check("mrst_ferr",    64'(frame_err),       64'h0);
        rst = 1'b0;
        clks(HALF);
        s0 = strobe_cnt; e0 = err_cnt;
        spi_bus.ncs = 1'b1;
        clks(2*HALF);
        check("mrst_no_ferr",   64'(err_cnt - e0),    64'd0);
        check("mrst_no_commit", 64'(strobe_cnt - s0), 64'd0);
        spi_frame(1'b1, 7'd0, 8'h11, 16, 1'b1, rd);
        check("post_rst_flat",    64'(regs_flat),       64'h00_00_00_00_11);
        check("post_rst_strobes", 64'(strobe_cnt - s0), 64'd1);

        // Back-to-back writes of regs 0..4
        s0 = strobe_cnt; e0 = err_cnt;
        for (int r = 0; r < 5; r++) begin
            spi_frame(1'b1, 7'(r), 8'(r + 1), 16, 1'b1, rd);
        end
        check("b2b_flat",    64'(regs_flat),       64'h05_04_03_02_01);
        check("b2b_strobes", 64'(strobe_cnt - s0), 64'd5);
        check("b2b_ferr",    64'(err_cnt - e0),    64'd0);
        check("b2b_wr_addr", 64'(wr_addr),         64'd4);
        spi_frame(1'b0, 7'd0, 8'h00, 16, 1'b1, rd);
        check("r0_data", 64'(rd), 64'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
